// File: rtl/vx_serial_div_unit.sv
// vx_serial_div_unit
//   Multi-lane iterative integer divider (restoring, one quotient bit per
//   cycle per lane). All lanes run in lockstep and one operation is in flight.
//   It supports signed and unsigned divide and remainder, 32-bit W-mode
//   (half-length iteration and sign-extended results), and a fast path taken
//   when every active lane divides by zero.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   valid_in / ready_in   request handshake (fire = valid_in && ready_in)
//   is_signed, is_rem     DIV/REM vs DIVU/REMU, quotient vs remainder
//   is_w                  32-bit W-mode (ignored when WIDTH == 32)
//   tmask_in              active-lane mask
//   numer, denom          per-lane operands, lane i at [i*WIDTH +: WIDTH]
//   tag_in                opaque tag returned with the response
//   valid_out / ready_out response handshake
//   result, tag_out       response payload, held stable while valid_out
//   busy                  high whenever the unit is not idle

module vx_serial_div_unit #(
    parameter int WIDTH = 64,
    parameter int LANES = 4,
    parameter int TAGW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic                   is_signed,
    input  logic                   is_rem,
    input  logic                   is_w,
    input  logic [LANES-1:0]       tmask_in,
    input  logic [LANES*WIDTH-1:0] numer,
    input  logic [LANES*WIDTH-1:0] denom,
    input  logic [TAGW-1:0]        tag_in,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [LANES*WIDTH-1:0] result,
    output logic [TAGW-1:0]        tag_out,
    output logic                   busy
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_W    = CNTW'(32);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    // Extend bit 31 upward: sign-extend when sgn=1, zero-extend when sgn=0.
    function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] o;
        o = v;
        for (int b = 32; b < WIDTH; b++) o[b] = sgn & v[31];
        return o;
    endfunction

    state_e                        state_q, state_d;
    logic [CNTW-1:0]               cnt_q, cnt_d;
    logic [LANES-1:0][WIDTH-1:0]   numer_q, numer_d;
    logic [LANES-1:0][WIDTH-1:0]   denom_q, denom_d;
    logic                          is_signed_q, is_signed_d;
    logic                          is_rem_q, is_rem_d;
    logic                          is_w_q, is_w_d;
    logic [LANES-1:0]              tmask_q, tmask_d;
    logic [TAGW-1:0]               tag_q, tag_d;
    logic [LANES-1:0][WIDTH-1:0]   result_q, result_d;
    logic [TAGW-1:0]               tag_out_q, tag_out_d;

    logic                          fire;
    logic                          lane_load;
    logic                          lane_step;
    logic [LANES-1:0]              dz;
    logic [LANES-1:0][WIDTH-1:0]   lane_res;

    // A new request may enter in the same cycle the previous response leaves.
    assign ready_in  = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_out);
    assign fire      = valid_in && ready_in;
    assign valid_out = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        numer_d     = numer_q;
        denom_d     = denom_q;
        is_signed_d = is_signed_q;
        is_rem_d    = is_rem_q;
        is_w_d      = is_w_q;
        tmask_d     = tmask_q;
        tag_d       = tag_q;
        result_d    = result_q;
        tag_out_d   = tag_out_q;
        lane_load   = 1'b0;
        lane_step   = 1'b0;

        if (fire) begin
            numer_d     = numer;
            denom_d     = denom;
            is_signed_d = is_signed;
            is_rem_d    = is_rem;
            is_w_d      = (WIDTH > 32) && is_w;
            tmask_d     = tmask_in;
            tag_d       = tag_in;
        end

        case (state_q)
            S_IDLE: if (fire) state_d = S_PREP;
            S_PREP: begin
                lane_load = 1'b1;
                // Nothing to iterate for if every active lane is a divide by
                // zero (an empty mask trivially qualifies).
                if ((dz & tmask_q) == tmask_q) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d   = is_w_q ? CNT_W : CNT_FULL;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                lane_step = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) state_d = S_FIX;
            end
            S_FIX: begin
                result_d  = lane_res;
                tag_out_d = tag_q;
                state_d   = S_DONE;
            end
            S_DONE: if (ready_out) state_d = fire ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            numer_q     <= '0;
            denom_q     <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            is_w_q      <= 1'b0;
            tmask_q     <= '0;
            tag_q       <= '0;
            result_q    <= '0;
            tag_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            numer_q     <= numer_d;
            denom_q     <= denom_d;
            is_signed_q <= is_signed_d;
            is_rem_q    <= is_rem_d;
            is_w_q      <= is_w_d;
            tmask_q     <= tmask_d;
            tag_q       <= tag_d;
            result_q    <= result_d;
            tag_out_q   <= tag_out_d;
        end
    end

    // Per-lane datapath. Operand views, signs and magnitudes are pure
    // functions of the latched request, so only the partial remainder and the
    // dividend/quotient shift register are stateful.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] r_q, r_d;
        logic [WIDTH-1:0] q_q, q_d;
        logic [WIDTH-1:0] n_view, d_view, n_mag, d_mag;
        logic [WIDTH-1:0] quo, rem, sel, res;
        logic             sn, sd, d_zero;
        logic [WIDTH:0]   r_sh, diff;

        always_comb begin
            n_view = is_w_q ? ext32(numer_q[i], is_signed_q) : numer_q[i];
            d_view = is_w_q ? ext32(denom_q[i], is_signed_q) : denom_q[i];
            sn     = is_signed_q & n_view[WIDTH-1];
            sd     = is_signed_q & d_view[WIDTH-1];
            n_mag  = sn ? -n_view : n_view;
            d_mag  = sd ? -d_view : d_view;
            d_zero = (d_view == '0);

            // Restoring step: shift in the next dividend bit, trial subtract,
            // keep the difference if it did not borrow.
            r_sh = {r_q, q_q[WIDTH-1]};
            diff = r_sh - {1'b0, d_mag};

            r_d = r_q;
            q_d = q_q;
            if (lane_load) begin
                r_d = '0;
                // W-mode left-aligns the 32-bit dividend so its MSB is shifted
                // out first; after 32 steps the quotient sits in the low half.
                q_d = is_w_q ? (n_mag << (WIDTH - 32)) : n_mag;
            end else if (lane_step) begin
                r_d = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], ~diff[WIDTH]};
            end

            // MIN / -1 needs no special case: the magnitude quotient 2^(n-1)
            // negates back to MIN and the remainder is already zero.
            quo = (sn ^ sd) ? -q_q : q_q;
            rem = sn ? -r_q : r_q;
            if (d_zero) begin
                quo = '1;
                rem = n_view;
            end
            sel = is_rem_q ? rem : quo;
            if (is_w_q) sel = ext32(sel, 1'b1);
            res = tmask_q[i] ? sel : '0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_q <= '0;
                q_q <= '0;
            end else begin
                r_q <= r_d;
                q_q <= q_d;
            end
        end

        assign dz[i]       = d_zero;
        assign lane_res[i] = res;
    end

endmodule

// File: tb/tb_vx_serial_div_unit.sv
module tb_vx_serial_div_unit;
  localparam int W = 64;
  localparam int L = 4;
  localparam int T = 8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           valid_in = 1'b0;
  logic           ready_in;
  logic           is_signed = 1'b0;
  logic           is_rem = 1'b0;
  logic           is_w = 1'b0;
  logic [L-1:0]   tmask_in = '0;
  logic [L*W-1:0] numer = '0;
  logic [L*W-1:0] denom = '0;
  logic [T-1:0]   tag_in = '0;
  logic           valid_out;
  logic           ready_out = 1'b1;
  logic [L*W-1:0] result;
  logic [T-1:0]   tag_out;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_serial_div_unit #(.WIDTH(W), .LANES(L), .TAGW(T)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .is_signed(is_signed), .is_rem(is_rem), .is_w(is_w), .tmask_in(tmask_in),
    .numer(numer), .denom(denom), .tag_in(tag_in), .valid_out(valid_out),
    .ready_out(ready_out), .result(result), .tag_out(tag_out), .busy(busy)
  );

  function automatic logic [63:0] lane(input int i);
    return result[i*64 +: 64];
  endfunction

  task automatic next();
    @(posedge clk); #1;
  endtask

  // Presents a request; caller sits at posedge+1.
  task automatic drive(input logic sg, input logic rm, input logic wm, input logic [3:0] m,
                       input logic [63:0] n0, input logic [63:0] n1, input logic [63:0] n2, input logic [63:0] n3,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3,
                       input logic [7:0] tg);
    is_signed = sg; is_rem = rm; is_w = wm; tmask_in = m;
    numer = {n3, n2, n1, n0};
    denom = {d3, d2, d1, d0};
    tag_in = tg;
    valid_in = 1'b1;
  endtask

  // Fire edge, then drop valid_in.
  task automatic fire_req();
    next();
    valid_in = 1'b0;
  endtask

  // Counts cycles from the fire cycle to the first cycle with valid_out=1.
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (valid_out !== 1'b1 && cyc < 200) begin
      next();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("FAIL rst_result got %h exp 0", result); end
    checks++; if (tag_out !== 8'h00) begin errors++; $display("FAIL rst_tag got %h exp 00", tag_out); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready_in); end
    next();
  endtask

  task automatic test_unsigned();
    int cyc;
    logic [63:0] e[4];
    drive(0, 0, 0, 4'b1111, 64'd100, ONES, 64'd50, 64'd0, 64'd7, 64'd1, 64'd5, 64'd3, 8'h11);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL udiv_latency got %0d exp 67", cyc); end
    checks++; if (tag_out !== 8'h11) begin errors++; $display("FAIL udiv_tag got %h exp 11", tag_out); end
    e = '{64'd14, ONES, 64'd10, 64'd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL udiv lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    drive(0, 1, 0, 4'b1111, 64'd100, ONES, 64'd50, 64'd0, 64'd7, 64'd1, 64'd5, 64'd3, 8'h12);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL urem_latency got %0d exp 67", cyc); end
    e = '{64'd2, 64'd0, 64'd0, 64'd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL urem lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
  endtask

  task automatic test_signed();
    int cyc;
    logic [63:0] e[4];
    drive(1, 0, 0, 4'b1111, -64'd7, MIN, 64'd7, -64'd8, 64'd2, ONES, -64'd2, -64'd3, 8'h21);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL sdiv_latency got %0d exp 67", cyc); end
    e = '{64'hFFFF_FFFF_FFFF_FFFD, MIN, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL sdiv lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    drive(1, 1, 0, 4'b1111, -64'd7, MIN, 64'd7, -64'd8, 64'd2, ONES, -64'd2, -64'd3, 8'h22);
    fire_req(); wait_resp(cyc);
    e = '{ONES, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL srem lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [63:0] e[4];
    drive(1, 0, 0, 4'b1111, 64'd5, 64'd5, -64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 8'h31);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL dz_div_latency got %0d exp 3", cyc); end
    e = '{ONES, ONES, ONES, ONES};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL dz_div lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    drive(1, 1, 0, 4'b1111, 64'd5, 64'd5, -64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 8'h32);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL dz_rem_latency got %0d exp 3", cyc); end
    e = '{64'd5, 64'd5, -64'd5, 64'd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL dz_rem lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    // Mixed zero / non-zero divisors take the full iteration.
    drive(0, 0, 0, 4'b1111, 64'd5, 64'd20, 64'd0, 64'd9, 64'd0, 64'd3, 64'd0, 64'd9, 8'h33);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL dz_mixed_latency got %0d exp 67", cyc); end
    e = '{ONES, 64'd6, ONES, 64'd1};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL dz_mixed lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
  endtask

  task automatic test_tmask();
    int cyc;
    logic [63:0] e[4];
    drive(0, 0, 0, 4'b0101, 64'd100, 64'd10, 64'd50, 64'd10, 64'd7, 64'd2, 64'd0, 64'd5, 8'h41);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL mask_latency got %0d exp 67", cyc); end
    e = '{64'd14, 64'd0, ONES, 64'd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL mask lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    // Only inactive lanes have real divisors: still the fast path.
    drive(0, 0, 0, 4'b0101, 64'd1, 64'd10, 64'd2, 64'd10, 64'd0, 64'd2, 64'd0, 64'd5, 8'h42);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL mask_fast_latency got %0d exp 3", cyc); end
    e = '{ONES, 64'd0, ONES, 64'd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL mask_fast lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    drive(0, 0, 0, 4'b0000, 64'd9, 64'd9, 64'd9, 64'd9, 64'd3, 64'd3, 64'd3, 64'd3, 8'h43);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL mask_zero_latency got %0d exp 3", cyc); end
    checks++; if (result !== '0) begin errors++; $display("FAIL mask_zero_result got %h exp 0", result); end
    next();
  endtask

  task automatic test_wmode();
    int cyc;
    logic [63:0] e[4];
    drive(0, 0, 1, 4'b1111, 64'h1234_5678_8000_0000, 64'd100, ONES, 64'd7,
          64'd1, 64'd7, 64'h0000_0001_0000_0002, 64'd0, 8'h51);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 35) begin errors++; $display("FAIL divuw_latency got %0d exp 35", cyc); end
    e = '{64'hFFFF_FFFF_8000_0000, 64'd14, 64'h0000_0000_7FFF_FFFF, ONES};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL divuw lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
    drive(1, 1, 1, 4'b1111, -64'd9, 64'd9, 64'hABCD_0000_0000_000B, -64'd9,
          64'd4, 64'd4, 64'd3, 64'd0, 8'h52);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 35) begin errors++; $display("FAIL remw_latency got %0d exp 35", cyc); end
    e = '{ONES, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFF7};
    for (int i = 0; i < 4; i++) begin
      checks++; if (lane(i) !== e[i]) begin errors++; $display("FAIL remw lane%0d got %h exp %h", i, lane(i), e[i]); end
    end
    next();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [L*W-1:0] exp1;
    exp1 = {64'd0, 64'd1, 64'd100, 64'd14};
    ready_out = 1'b0;
    drive(0, 0, 0, 4'b1111, 64'd100, 64'd1000, 64'd7, 64'd3, 64'd7, 64'd10, 64'd7, 64'd5, 8'hA5);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL bp_latency got %0d exp 67", cyc); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (valid_out !== 1'b1 || ready_in !== 1'b0 || result !== exp1 || tag_out !== 8'hA5) begin
        errors++;
        $display("FAIL bp_hold cyc%0d valid %b ready_in %b tag %h result %h", k, valid_out, ready_in, tag_out, result);
      end
      next();
    end
    drive(1, 1, 0, 4'b1111, -64'd7, MIN, 64'd7, -64'd8, 64'd2, ONES, -64'd2, -64'd3, 8'h5A);
    ready_out = 1'b1;
    #1;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ready_in); end
    fire_req();
    checks++; if (valid_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_consume valid %b busy %b exp 0 1", valid_out, busy); end
    wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL b2b_latency got %0d exp 67", cyc); end
    checks++; if (tag_out !== 8'h5A) begin errors++; $display("FAIL b2b_tag got %h exp 5A", tag_out); end
    checks++; if (lane(0) !== ONES) begin errors++; $display("FAIL b2b lane0 got %h exp %h", lane(0), ONES); end
    checks++; if (lane(3) !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL b2b lane3 got %h exp fffffffffffffffe", lane(3)); end
    next();
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic stale;
    drive(0, 0, 0, 4'b1111, 64'd100, 64'd1000, 64'd7, 64'd3, 64'd7, 64'd10, 64'd7, 64'd5, 8'h66);
    fire_req();
    repeat (10) next();
    reset = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst valid %b busy %b exp 0 0", valid_out, busy); end
    checks++; if (result !== '0 || tag_out !== 8'h00) begin errors++; $display("FAIL midrst_clear tag %h result %h exp 0", tag_out, result); end
    @(posedge clk); #1 reset = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 80; k++) begin
      next();
      if (valid_out !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale got 1 exp 0"); end
    drive(0, 1, 0, 4'b1111, 64'd100, 64'd1000, 64'd7, 64'd3, 64'd7, 64'd10, 64'd7, 64'd5, 8'h77);
    fire_req(); wait_resp(cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL midrst_latency got %0d exp 67", cyc); end
    checks++; if (tag_out !== 8'h77) begin errors++; $display("FAIL midrst_tag got %h exp 77", tag_out); end
    checks++; if (result !== {64'd3, 64'd0, 64'd0, 64'd2}) begin errors++; $display("FAIL midrst_result got %h", result); end
    next();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_tmask();
    test_wmode();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
